// File: rtl/uart_elf_loader.sv
// uart_elf_loader
// Receives firmware sections over a UART 8N1 line (address, length, payload)
// and writes each payload into RAM with single-beat AXI4 writes. Raises a
// sticky done flag on the zero-length terminator section, or a sticky error
// flag on a framing error, an overrun, a bad header or an error response.
module uart_elf_loader #(
    parameter int          AXI_DATA_WIDTH = 64,
    parameter int          AXI_ADDR_WIDTH = 64,
    parameter logic [31:0] RAM_BASE       = 32'h8000_0000,
    parameter logic [31:0] RAM_LENGTH     = 32'h0010_0000,
    parameter int          CLKS_PER_BIT   = 434
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [AXI_ADDR_WIDTH-1:0]     aw_addr_o,
    output logic [2:0]                    aw_size_o,
    output logic                          aw_valid_o,
    input  logic                          aw_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
    output logic                          w_last_o,
    output logic                          w_valid_o,
    input  logic                          w_ready_i,
    input  logic [1:0]                    b_resp_i,
    input  logic                          b_valid_i,
    output logic                          b_ready_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int NB    = AXI_DATA_WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_LANE  = IDX_W'(NB - 1);
    localparam logic [31:0]      ALIGN_MASK = 32'(NB - 1);
    // One past the last writable byte, kept 33 bits wide so nothing wraps.
    localparam logic [32:0]      RAM_END    = {1'b0, RAM_BASE} + {1'b0, RAM_LENGTH};

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        HDR,
        CHECK,
        DATA,
        AW_W,
        RESP,
        DONE,
        ERR
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic             rx_meta_reg;
    logic             rx_sync_reg;
    rx_state_t        rx_state_reg;
    logic [CNT_W-1:0] rx_cnt_reg;
    logic [2:0]       rx_bit_reg;
    logic [7:0]       rx_shift_reg;

    logic             hold_valid_reg;
    logic [7:0]       hold_data_reg;

    logic             stop_sample;
    logic             frame_err;
    logic             overrun;
    logic             rx_fault;
    logic             consume;

    state_t                  state_reg,     state_next;
    logic [63:0]             hdr_reg,       hdr_next;
    logic [2:0]              hdr_cnt_reg,   hdr_cnt_next;
    logic [31:0]             addr_reg,      addr_next;
    logic [31:0]             remaining_reg, remaining_next;
    logic [IDX_W-1:0]        byte_idx_reg,  byte_idx_next;
    logic [AXI_DATA_WIDTH-1:0] buf_data_reg, buf_data_next;
    logic [NB-1:0]           buf_strb_reg,  buf_strb_next;
    logic                    aw_pend_reg,   aw_pend_next;
    logic                    w_pend_reg,    w_pend_next;

    logic [31:0]  hdr_addr;
    logic [31:0]  hdr_len;
    logic [32:0]  hdr_end;
    logic         hdr_bad;
    logic [NB-1:0] lane_sel;

    // ------------------------------------------------------------------
    // RX front end
    // ------------------------------------------------------------------

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // Bit-timing engine: start bit re-checked mid-bit, then data and stop
    // bits sampled once per bit period at the same phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        rx_cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == HALF_BIT) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        // A start bit that is high again was only a glitch.
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == LAST_TICK) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        rx_bit_reg   <= rx_bit_reg + 3'd1;
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == LAST_TICK) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    assign stop_sample = (rx_state_reg == RX_STOP) && (rx_cnt_reg == LAST_TICK);
    assign consume     = hold_valid_reg && ((state_reg == HDR) || (state_reg == DATA));
    assign frame_err   = stop_sample && !rx_sync_reg;
    // A byte landing on an unconsumed one is lost; a same-cycle consume frees the slot.
    assign overrun     = stop_sample && rx_sync_reg && hold_valid_reg && !consume;
    assign rx_fault    = frame_err || overrun;

    // One-byte holding register between the receiver and the loader FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else if (stop_sample && rx_sync_reg) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= rx_shift_reg;
        end else if (consume) begin
            hold_valid_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    assign hdr_addr = hdr_reg[31:0];
    assign hdr_len  = hdr_reg[63:32];
    assign hdr_end  = {1'b0, hdr_addr} + {1'b0, hdr_len};
    assign hdr_bad  = ((hdr_addr & ALIGN_MASK) != 32'd0) ||
                      (hdr_addr < RAM_BASE) ||
                      (hdr_end > RAM_END);

    // Decode of the word lane the next payload byte lands in.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_sel[gi] = (byte_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HDR;
            hdr_reg       <= '0;
            hdr_cnt_reg   <= '0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            byte_idx_reg  <= '0;
            buf_data_reg  <= '0;
            buf_strb_reg  <= '0;
            aw_pend_reg   <= 1'b0;
            w_pend_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hdr_reg       <= hdr_next;
            hdr_cnt_reg   <= hdr_cnt_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            byte_idx_reg  <= byte_idx_next;
            buf_data_reg  <= buf_data_next;
            buf_strb_reg  <= buf_strb_next;
            aw_pend_reg   <= aw_pend_next;
            w_pend_reg    <= w_pend_next;
        end
    end

    // Next-state logic: header collection, range check, word packing and
    // the AXI write/response sequence.
    always_comb begin
        state_next     = state_reg;
        hdr_next       = hdr_reg;
        hdr_cnt_next   = hdr_cnt_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        byte_idx_next  = byte_idx_reg;
        buf_data_next  = buf_data_reg;
        buf_strb_next  = buf_strb_reg;
        aw_pend_next   = aw_pend_reg;
        w_pend_next    = w_pend_reg;

        case (state_reg)
            HDR: begin
                if (consume) begin
                    // Little-endian fields: shifting in from the top leaves
                    // the address in [31:0] and the length in [63:32].
                    hdr_next     = {hold_data_reg, hdr_reg[63:8]};
                    hdr_cnt_next = hdr_cnt_reg + 3'd1;
                    if (hdr_cnt_reg == 3'd7) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (hdr_len == 32'd0) begin
                    state_next = DONE;
                end else if (hdr_bad) begin
                    state_next = ERR;
                end else begin
                    state_next     = DATA;
                    addr_next      = hdr_addr;
                    remaining_next = hdr_len;
                    byte_idx_next  = '0;
                    buf_data_next  = '0;
                    buf_strb_next  = '0;
                end
            end
            DATA: begin
                if (consume) begin
                    for (int k = 0; k < NB; k++) begin
                        if (lane_sel[k]) begin
                            buf_data_next[8*k +: 8] = hold_data_reg;
                            buf_strb_next[k]        = 1'b1;
                        end
                    end
                    remaining_next = remaining_reg - 32'd1;
                    byte_idx_next  = byte_idx_reg + IDX_W'(1);
                    if ((byte_idx_reg == LAST_LANE) || (remaining_reg == 32'd1)) begin
                        state_next   = AW_W;
                        aw_pend_next = 1'b1;
                        w_pend_next  = 1'b1;
                    end
                end
            end
            AW_W: begin
                // AW and W complete independently; leave once both are taken.
                aw_pend_next = aw_pend_reg && !aw_ready_i;
                w_pend_next  = w_pend_reg && !w_ready_i;
                if (!aw_pend_next && !w_pend_next) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (b_valid_i) begin
                    if (b_resp_i != 2'b00) begin
                        state_next = ERR;
                    end else begin
                        addr_next     = addr_reg + 32'(NB);
                        byte_idx_next = '0;
                        buf_data_next = '0;
                        buf_strb_next = '0;
                        state_next    = (remaining_reg != 32'd0) ? DATA : HDR;
                    end
                end
            end
            DONE: state_next = DONE;
            ERR:  state_next = ERR;
            default: state_next = ERR;
        endcase

        // Receiver faults halt the loader unless it has already stopped.
        if (rx_fault && (state_reg != DONE) && (state_reg != ERR)) begin
            state_next = ERR;
        end
        if (state_next == ERR) begin
            aw_pend_next = 1'b0;
            w_pend_next  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign aw_addr_o  = AXI_ADDR_WIDTH'(addr_reg);
    assign aw_size_o  = 3'($clog2(NB));
    assign aw_valid_o = aw_pend_reg;
    assign w_data_o   = buf_data_reg;
    assign w_strb_o   = buf_strb_reg;
    assign w_last_o   = 1'b1;
    assign w_valid_o  = w_pend_reg;
    assign b_ready_o  = (state_reg == RESP);
    assign busy_o     = ((state_reg == HDR) && (hdr_cnt_reg != 3'd0)) ||
                        (state_reg == CHECK) || (state_reg == DATA) ||
                        (state_reg == AW_W)  || (state_reg == RESP);
    assign done_o     = (state_reg == DONE);
    assign err_o      = (state_reg == ERR);

endmodule

// File: tb/tb_uart_elf_loader.sv
// Testbench for uart_elf_loader: serial section stimulus, an AXI responder,
// and a scoreboard monitor that matches every observed write against a
// queue of hand-computed expected writes.
module tb_uart_elf_loader;

    localparam int          CPB  = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] RLEN = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [63:0] aw_addr_o;
    logic [2:0]  aw_size_o;
    logic        aw_valid_o;
    logic        aw_ready_i = 1'b1;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_last_o;
    logic        w_valid_o;
    logic        w_ready_i = 1'b1;
    logic [1:0]  b_resp_i = 2'b00;
    logic        b_valid_i = 1'b0;
    logic        b_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    uart_elf_loader #(
        .AXI_DATA_WIDTH (64),
        .AXI_ADDR_WIDTH (64),
        .RAM_BASE       (BASE),
        .RAM_LENGTH     (RLEN),
        .CLKS_PER_BIT   (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .aw_addr_o  (aw_addr_o),
        .aw_size_o  (aw_size_o),
        .aw_valid_o (aw_valid_o),
        .aw_ready_i (aw_ready_i),
        .w_data_o   (w_data_o),
        .w_strb_o   (w_strb_o),
        .w_last_o   (w_last_o),
        .w_valid_o  (w_valid_o),
        .w_ready_i  (w_ready_i),
        .b_resp_i   (b_resp_i),
        .b_valid_i  (b_valid_i),
        .b_ready_o  (b_ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] got_aw_q[$];
    logic [71:0] got_w_q[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_writes = 0;
    int          b_owed = 0;
    bit          b_hs = 1'b0;
    bit          bad_resp_once = 1'b0;
    int          aw_stall_cnt = 0;
    int          stall_cycles = 0;
    bit          prev_stalled = 1'b0;
    logic [63:0] prev_addr = '0;
    bit          w_before_aw = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        check(name, 64'(act), 64'(req));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
        wr_t e;
        e.addr = 64'(addr);
        e.data = data;
        e.strb = strb;
        exp_q.push_back(e);
    endtask

    task automatic uart_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
    endtask

    task automatic send_section(input logic [31:0] addr, input logic [31:0] len,
                                input logic [7:0] first, input int npay);
        logic [7:0] pb;
        $display("section addr=%h len=%0d payload_bytes=%0d", addr, len, npay);
        for (int i = 0; i < 4; i++) uart_byte(addr[8*i +: 8], 1'b0);
        for (int i = 0; i < 4; i++) uart_byte(len[8*i +: 8], 1'b0);
        for (int i = 0; i < npay; i++) begin
            pb = first + 8'(i);
            uart_byte(pb, 1'b0);
        end
    endtask

    // Bounded wait for every expected write to be seen and responded.
    task automatic wait_quiet(input string name);
        int k;
        k = 0;
        while ((k < 400) && ((exp_q.size() != 0) || (b_owed != 0) ||
                             aw_valid_o || w_valid_o || b_valid_i)) begin
            tick(1);
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        tick(4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    // AXI responder and scoreboard monitor, all on the falling edge so the
    // drives land between DUT edges and DUT outputs are sampled when stable.
    always @(negedge clk) begin
        wr_t         e;
        logic [63:0] a;
        logic [71:0] w;
        if (!rst_n) begin
            b_valid_i    = 1'b0;
            b_hs         = 1'b0;
            b_owed       = 0;
            prev_stalled = 1'b0;
            got_aw_q.delete();
            got_w_q.delete();
        end else begin
            if (b_hs) begin
                b_valid_i = 1'b0;
                b_hs      = 1'b0;
                b_owed--;
            end else if (!b_valid_i && (b_owed > 0)) begin
                b_valid_i     = 1'b1;
                b_resp_i      = bad_resp_once ? 2'b10 : 2'b00;
                bad_resp_once = 1'b0;
            end
            if (b_valid_i && b_ready_o) b_hs = 1'b1;

            if (aw_stall_cnt > 0) begin
                aw_ready_i = 1'b0;
                if (aw_valid_o) aw_stall_cnt--;
            end else begin
                aw_ready_i = 1'b1;
            end

            if (aw_valid_o && !aw_ready_i) begin
                stall_cycles++;
                if (prev_stalled) check("aw_addr_stable", aw_addr_o, prev_addr);
                prev_stalled = 1'b1;
                prev_addr    = aw_addr_o;
            end else begin
                prev_stalled = 1'b0;
            end

            if (aw_valid_o && aw_ready_i) got_aw_q.push_back(aw_addr_o);
            if (w_valid_o && w_ready_i) begin
                if (got_aw_q.size() == 0) w_before_aw = 1'b1;
                got_w_q.push_back({w_strb_o, w_data_o});
            end

            if ((got_aw_q.size() > 0) && (got_w_q.size() > 0)) begin
                a = got_aw_q.pop_front();
                w = got_w_q.pop_front();
                b_owed++;
                n_writes++;
                $display("write addr=%h data=%h strb=%h", a, w[63:0], w[71:64]);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: actual addr=%h required no write", a);
                end else begin
                    e = exp_q.pop_front();
                    check("aw_addr", a, e.addr);
                    check("w_data", w[63:0], e.data);
                    check("w_strb", {56'd0, w[71:64]}, {56'd0, e.strb});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;

        // Reset values
        do_reset();
        check1("rst_aw_valid", aw_valid_o, 1'b0);
        check1("rst_w_valid", w_valid_o, 1'b0);
        check1("rst_b_ready", b_ready_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_done", done_o, 1'b0);
        check1("rst_err", err_o, 1'b0);
        check("aw_size", 64'(aw_size_o), 64'd3);
        check1("w_last", w_last_o, 1'b1);

        // One full word
        push_exp(BASE, 64'h0807060504030201, 8'hFF);
        send_section(BASE, 32'd8, 8'h01, 8);
        wait_quiet("s1_drained");
        check1("s1_busy_idle", busy_o, 1'b0);

        // Full word plus a 3-byte tail, then the terminator
        push_exp(BASE + 32'd8,  64'h1817161514131211, 8'hFF);
        push_exp(BASE + 32'd16, 64'h00000000001B1A19, 8'h07);
        send_section(BASE + 32'd8, 32'd11, 8'h11, 11);
        wait_quiet("s2_drained");
        send_section(32'h0, 32'd0, 8'h00, 0);
        tick(8);
        check1("s2_done", done_o, 1'b1);
        check1("s2_err", err_o, 1'b0);
        check1("s2_busy", busy_o, 1'b0);

        // AW stalled 5 cycles while W is accepted immediately
        do_reset();
        stall_cycles = 0;
        w_before_aw  = 1'b0;
        w0 = n_writes;
        aw_stall_cnt = 5;
        push_exp(BASE + 32'h40, 64'hA7A6A5A4A3A2A1A0, 8'hFF);
        send_section(BASE + 32'h40, 32'd8, 8'hA0, 8);
        wait_quiet("s3_drained");
        check("s3_stall_cycles", 64'(stall_cycles), 64'd5);
        check1("s3_w_first", w_before_aw, 1'b1);
        check("s3_write_count", 64'(n_writes - w0), 64'd1);

        // Error response on the first write halts the loader
        do_reset();
        w0 = n_writes;
        bad_resp_once = 1'b1;
        push_exp(BASE, 64'h3736353433323130, 8'hFF);
        send_section(BASE, 32'd16, 8'h30, 16);
        wait_quiet("s4_drained");
        check1("s4_err", err_o, 1'b1);
        check1("s4_busy", busy_o, 1'b0);
        check("s4_write_count", 64'(n_writes - w0), 64'd1);

        // Rejected headers: unaligned, unaligned at the top, overflow, below base
        do_reset();
        w0 = n_writes;
        send_section(BASE + 32'd4, 32'd8, 8'h40, 8);
        tick(8);
        check1("s5_unaligned_err", err_o, 1'b1);
        check("s5_unaligned_writes", 64'(n_writes - w0), 64'd0);

        do_reset();
        send_section(BASE + RLEN - 32'd4, 32'd8, 8'h48, 2);
        tick(8);
        check1("s5_top_unaligned_err", err_o, 1'b1);

        do_reset();
        send_section(BASE + RLEN - 32'd8, 32'd16, 8'h50, 2);
        tick(8);
        check1("s5_overflow_err", err_o, 1'b1);

        do_reset();
        send_section(BASE - 32'd8, 32'd8, 8'h58, 2);
        tick(8);
        check1("s5_below_err", err_o, 1'b1);
        check("s5_total_writes", 64'(n_writes - w0), 64'd0);

        // Last legal word of RAM is accepted
        do_reset();
        push_exp(BASE + RLEN - 32'd8, 64'hE7E6E5E4E3E2E1E0, 8'hFF);
        send_section(BASE + RLEN - 32'd8, 32'd8, 8'hE0, 8);
        wait_quiet("s6_drained");
        check1("s6_top_ok_err", err_o, 1'b0);

        // Framing error on a header byte
        do_reset();
        $display("section framing error on first header byte");
        uart_byte(8'h00, 1'b1);
        tick(8);
        check1("s7_frame_err", err_o, 1'b1);

        // Reset mid-payload, then a clean section and terminator
        do_reset();
        send_section(BASE + 32'h100, 32'd16, 8'h60, 3);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check1("s8_busy_after_rst", busy_o, 1'b0);
        check1("s8_err_after_rst", err_o, 1'b0);
        w0 = n_writes;
        push_exp(BASE + 32'h200, 64'hC7C6C5C4C3C2C1C0, 8'hFF);
        send_section(BASE + 32'h200, 32'd8, 8'hC0, 8);
        wait_quiet("s8_drained");
        send_section(32'h0, 32'd0, 8'h00, 0);
        tick(8);
        check1("s8_done", done_o, 1'b1);
        check1("s8_err", err_o, 1'b0);
        check("s8_write_count", 64'(n_writes - w0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
